// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the wait-state data memory
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int MAX_WAIT = 15;
  function automatic int lane_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction
endpackage

// File: rtl/dmem_sp_ram.sv
// dmem_sp_ram: single-port word array with per-byte write enable and async read
module dmem_sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    idx,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // byte-lane write; contents deliberately carry no reset
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < DATA_W / 8; i++)
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: data memory with wait states, req/ready handshake, error flag and stall
module dmem_wait_ctrl import dmem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                stall
);
  localparam int NB = DATA_W / 8;
  localparam int SH = lane_shift(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << SH) - 1);
  state_t state, nxt;
  logic [3:0] cnt, cnt_n;
  logic l_we, l_err;
  logic [NB-1:0] l_be;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic idle, in_err, c_we, c_err, enter;
  logic [NB-1:0] c_be;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata, ram_rdata;
  // in IDLE the live inputs drive the array so a zero-wait access can commit on its acceptance edge
  assign idle    = state == IDLE;
  assign in_err  = |(addr & LANE_MASK) || (addr >> SH) >= ADDR_W'(DEPTH);
  assign c_we    = idle ? we : l_we;
  assign c_be    = idle ? be : l_be;
  assign c_addr  = idle ? addr : l_addr;
  assign c_wdata = idle ? wdata : l_wdata;
  assign c_err   = idle ? in_err : l_err;
  assign enter   = nxt == RESP;
  assign ready   = state == RESP;
  assign stall   = req & ~ready;
  dmem_sp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk(clk),
    .we(enter & c_we & ~c_err),
    .be(c_be),
    .idx(IDX_W'(c_addr >> SH)),
    .wdata(c_wdata),
    .rdata(ram_rdata)
  );
  // next state and wait counter
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (req) begin
        nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
        cnt_n = CNT_INIT;
      end
      WAIT: if (cnt == 4'd0) nxt = RESP; else cnt_n = cnt - 4'd1;
      default: nxt = IDLE;
    endcase
  end
  // state, counter, latched request and registered response
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      l_we <= 1'b0;
      l_err <= 1'b0;
      l_be <= '0;
      l_addr <= '0;
      l_wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      if (idle && req) begin
        l_we <= we;
        l_err <= in_err;
        l_be <= be;
        l_addr <= addr;
        l_wdata <= wdata;
      end
      rdata <= (enter && !c_we && !c_err) ? ram_rdata : '0;
      err <= enter && c_err;
    end
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: three configurations checked against a word-array reference model
module tb_dmem_wait_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] req, we, ready, err, stall;
  logic [7:0] be [3];
  logic [31:0] addr [3];
  logic [63:0] wdata [3];
  logic [31:0] rd0, rd2;
  logic [63:0] rd1, got;
  logic [63:0] m [3][32];
  int wc [3] = '{2, 5, 0};
  int dep [3] = '{32, 16, 32};
  int nb [3] = '{4, 8, 4};
  int sh [3] = '{2, 3, 2};
  int n_chk = 0, n_fail = 0;
  bit seen;
  always #5 clk = ~clk;
  dmem_wait_ctrl u_w2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .be(be[0][3:0]), .addr(addr[0]),
    .wdata(wdata[0][31:0]), .rdata(rd0), .ready(ready[0]), .err(err[0]), .stall(stall[0])
  );
  dmem_wait_ctrl #(.DATA_W(64), .DEPTH(16), .WAIT_CYCLES(5)) u_w64 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rd1), .ready(ready[1]), .err(err[1]), .stall(stall[1])
  );
  dmem_wait_ctrl #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .be(be[2][3:0]), .addr(addr[2]),
    .wdata(wdata[2][31:0]), .rdata(rd2), .ready(ready[2]), .err(err[2]), .stall(stall[2])
  );
  function automatic logic [63:0] rd_of(input int k);
    return (k == 0) ? {32'b0, rd0} : (k == 1) ? rd1 : {32'b0, rd2};
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input int k, input bit w, input logic [7:0] b, input logic [31:0] a,
                        input logic [63:0] d, output logic [63:0] r);
    logic [63:0] exp;
    bit e, st_ok;
    int idx, n;
    idx = int'(a >> sh[k]);
    e = ((a & ((32'd1 << sh[k]) - 32'd1)) != 0) || idx >= dep[k];
    exp = (!e && !w) ? m[k][idx] : 64'd0;
    if (!e && w)
      for (int i = 0; i < nb[k]; i++) if (b[i]) m[k][idx][i*8 +: 8] = d[i*8 +: 8];
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    #1;
    st_ok = stall[k];
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (ready[k] || n > 40) break;
      if (!stall[k]) st_ok = 1'b0;
    end
    check("latency", 64'(n), 64'(wc[k] + 1));
    check("stall_hold", 64'(st_ok), 64'd1);
    check("stall_resp", 64'(stall[k]), 64'd0);
    check("err", 64'(err[k]), 64'(e));
    r = rd_of(k);
    check("rdata", r, exp);
    req[k] = 1'b0;
  endtask
  initial begin
    req = '0; we = '0;
    for (int k = 0; k < 3; k++) begin
      be[k] = '0; addr[k] = '0; wdata[k] = '0;
      for (int i = 0; i < 32; i++) m[k][i] = '0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 64'(ready[k]), 64'd0);
      check("rst_err", 64'(err[k]), 64'd0);
      check("rst_rdata", rd_of(k), 64'd0);
      check("rst_stall", 64'(stall[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < dep[k]; i++) access(k, 1'b1, 8'hFF, 32'(i) << sh[k], 64'(i), got);
    access(0, 1'b0, 8'h0, 32'h08, 64'd0, got);
    check("basic_read", got, 64'h2);
    access(0, 1'b1, 8'b0110, 32'h14, 64'hAABBCCDD, got);
    access(0, 1'b0, 8'h0, 32'h14, 64'd0, got);
    check("be_merge", got, 64'h00BBCC05);
    access(0, 1'b0, 8'h0, 32'h02, 64'd0, got);
    access(0, 1'b1, 8'hFF, 32'h80, 64'hFFFFFFFF, got);
    access(0, 1'b0, 8'h0, 32'h00, 64'd0, got);
    check("err_no_write", got, 64'h0);
    access(1, 1'b0, 8'h0, 32'h08, 64'd0, got);
    check("w64_word1", got, 64'h1);
    access(1, 1'b0, 8'h0, 32'h04, 64'd0, got);
    access(2, 1'b1, 8'hFF, 32'h0C, 64'h12345678, got);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0C;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("b2b_ready", 64'(ready[2]), 64'(c % 2));
      if (c % 2 == 1) check("b2b_rdata", rd_of(2), 64'h12345678);
    end
    req[2] = 1'b0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; be[0] = 8'hFF; addr[0] = 32'h10; wdata[0] = 64'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req[0] = 1'b0;
    #1;
    check("midrst_ready", 64'(ready[0]), 64'd0);
    check("midrst_stall", 64'(stall[0]), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready[0]) seen = 1'b1;
      if (c == 2) rst = 1'b1;
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    access(0, 1'b0, 8'h0, 32'h10, 64'd0, got);
    check("midrst_discard", got, 64'h4);
    for (int t = 0; t < 120; t++) begin
      int k, idx;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      idx = $urandom_range(0, dep[k] + 1);
      a = 32'(idx) << sh[k];
      if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, (1 << sh[k]) - 1);
      if ($urandom_range(0, 15) == 0) a = 32'hFFFFFFF0;
      access(k, 1'($urandom_range(0, 1)), 8'($urandom), a, {$urandom, $urandom}, got);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
